pulse_counter_mc: RTL
=====================

Name: pulse_counter_mc

Overview:
- Multichannel successor to the single-channel plus/minus pulse counter in the detector front-end.
- Counts detector pulses on NCH channels, split by gate state: gate high counts into the plus accumulator, gate low into the minus accumulator.
- Every PERIOD_TICKS enable ticks, latches all accumulators into output registers, clears them and strobes data_valid for the host readout logic.
- Adds channel count, width, saturation mode and periodic snapshotting over the previous generation.

Parameters:
NCH, 4, number of pulse input channels (1..16)
WIDTH, 24, accumulator and output width per channel
PERIOD_TICKS, 4000000, en_tick strobes per measurement period (>=2)
SATURATE, 1, 1 = clamp at all-ones, 0 = wrap modulo 2^WIDTH
SYNC_STAGES, 2, synchroniser depth on pulse_in and gate (>=2)

Ports:
clk  input  1  system clock (12 MHz)
reset  input  1  asynchronous active-low reset
en_tick  input  1  one-clk-wide period timebase strobe (divided clock enable, 4 MHz)
gate  input  1  asynchronous plus/minus window select
pulse_in  input  NCH  asynchronous detector pulses, one bit per channel
clear  input  1  synchronous abort: discard current period, restart
count_p  output  NCH*WIDTH  latched plus counts, channel k at bits [k*WIDTH +: WIDTH]
count_m  output  NCH*WIDTH  latched minus counts, same packing
data_valid  output  1  one-clk strobe, new snapshot in count_p/count_m
overflow  output  NCH  per channel: plus or minus accumulator hit limit in latched period
period_cnt  output  32  number of completed periods since reset (wraps)

Behaviour:
- Reset (reset=0, asynchronous): all accumulators, outputs, synchronisers, tick counter, period_cnt = 0; data_valid = 0; overflow = 0. Outputs reload only on a later snapshot.
- Input conditioning: pulse_in and gate pass through SYNC_STAGES flops. A pulse event is a rising edge on the synchronised pulse_in (previous=0, current=1). Minimum countable pulse width is 1 clk high plus 1 clk low. Latency from pin to accumulator update is SYNC_STAGES+1 clk.
- Counting: each event increments acc_p[k] if synchronised gate=1, else acc_m[k]. Gate is sampled in the same clk as the edge detect.
- Limit handling: increment at all-ones with SATURATE=1 holds the value and sets ovf_live[k]. With SATURATE=0 it wraps to 0 and sets ovf_live[k].
- Timebase: tick_cnt increments on en_tick. When tick_cnt = PERIOD_TICKS-1 and en_tick=1, a snapshot occurs in that clk, and tick_cnt returns to 0.
- Snapshot (registered):
  - count_p/count_m <= acc_p/acc_m including any event in the same clk.
  - overflow <= ovf_live including same-clk overflow.
  - accumulators and ovf_live <= 0, with the same-clk event discarded into the old period (counted in snapshot, not in new period).
  - data_valid = 1 for exactly the next clk.
  - period_cnt += 1.
- FSM states:
  - IDLE: after reset, until first en_tick. Events are ignored.
  - RUN: counting. Transitions to SNAP on the snapshot condition.
  - SNAP: 1 clk, drives data_valid, returns to RUN. An event arriving in SNAP counts into the new period.
- clear=1: accumulators, ovf_live and tick_cnt <= 0; FSM -> IDLE. Outputs and period_cnt are held. No data_valid is produced. clear has priority over a simultaneous snapshot.
- Gate change: takes effect on the next synchronised sample. There is no masking around gate edges.
- en_tick asserted for consecutive clks counts each clk.

Test Plan:
1. Reset then release, en_tick every 3 clk, PERIOD_TICKS=10, no pulses -> data_valid at 30 clk cadence, count_p=count_m=0, period_cnt 1,2,3.
2. gate=1, 5 pulses on ch0, 3 on ch2; gate=0, 7 pulses on ch1 within one period -> snapshot ch0 p=5, ch2 p=3, ch1 m=7, all others 0, overflow=0.
3. WIDTH=4, SATURATE=1, 20 pulses ch0 gate=1 -> count_p ch0=15, overflow[0]=1. Repeat with SATURATE=0 -> count_p ch0=4, overflow[0]=1. Next empty period -> overflow=0.
4. Pulse edge in same clk as snapshot -> included in latched count; pulse in SNAP clk -> appears in following period.
5. clear mid-period after 4 pulses -> no data_valid, prior outputs unchanged; next period counts only post-clear pulses.
6. Assert reset=0 mid-period with counts pending -> all outputs 0 immediately (asynchronously), period_cnt=0; counting resumes after release.

Source files
------------

// File: rtl/pulse_counter_mc.sv
// Multichannel plus/minus pulse counter.
// Each channel counts rising edges of its synchronised pulse input into a
// plus or minus accumulator according to the synchronised gate level. Every
// PERIOD_TICKS en_tick strobes the accumulators are latched into the output
// registers, cleared, and data_valid is strobed for one clock.
module pulse_counter_mc #(
    parameter int NCH          = 4,
    parameter int WIDTH        = 24,
    parameter int PERIOD_TICKS = 4000000,
    parameter int SATURATE     = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_tick,
    input  logic                 gate,
    input  logic [NCH-1:0]       pulse_in,
    input  logic                 clear,
    output logic [NCH*WIDTH-1:0] count_p,
    output logic [NCH*WIDTH-1:0] count_m,
    output logic                 data_valid,
    output logic [NCH-1:0]       overflow,
    output logic [31:0]          period_cnt
);

    localparam int TW = $clog2(PERIOD_TICKS);
    localparam logic [TW-1:0] LAST_TICK = TW'(PERIOD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SNAP = 2'd2
    } state_t;

    // Input conditioning
    logic [NCH-1:0]         pulse_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] gate_sync_q;
    logic [NCH-1:0]         pulse_prev_q;
    logic [NCH-1:0]         evt;
    logic                   gate_s;

    // Per-period accumulation
    logic [WIDTH-1:0] acc_p_q  [NCH];
    logic [WIDTH-1:0] acc_m_q  [NCH];
    logic [WIDTH-1:0] acc_p_ev [NCH];
    logic [WIDTH-1:0] acc_m_ev [NCH];
    logic [WIDTH-1:0] acc_p_d  [NCH];
    logic [WIDTH-1:0] acc_m_d  [NCH];
    logic [WIDTH:0]   inc_p    [NCH];
    logic [WIDTH:0]   inc_m    [NCH];
    logic [NCH-1:0]   ovf_live_q;
    logic [NCH-1:0]   ovf_ev;
    logic [NCH-1:0]   ovf_live_d;

    // Control and latched outputs
    state_t               state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic                 data_valid_q;
    logic [31:0]          period_cnt_q;
    logic [NCH*WIDTH-1:0] count_p_q;
    logic [NCH*WIDTH-1:0] count_m_q;
    logic [NCH-1:0]       overflow_q;
    logic                 count_en;
    logic                 snap;

    // Increment with limit handling: bit WIDTH flags that the counter was
    // already all-ones, low bits hold the clamped or wrapped result.
    function automatic logic [WIDTH:0] limit_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        if (&v) begin
            r[WIDTH]     = 1'b1;
            r[WIDTH-1:0] = (SATURATE != 0) ? v : {WIDTH{1'b0}};
        end else begin
            r[WIDTH]     = 1'b0;
            r[WIDTH-1:0] = v + WIDTH'(1);
        end
        return r;
    endfunction

    assign evt    = pulse_sync_q[SYNC_STAGES-1] & ~pulse_prev_q;
    assign gate_s = gate_sync_q[SYNC_STAGES-1];

    // Events seen while IDLE are dropped; SNAP already belongs to the new period.
    assign count_en = (state_q != IDLE);
    // clear wins over a coincident period end, so no snapshot is taken then.
    assign snap     = (state_q == RUN) && en_tick && (tick_cnt_q == LAST_TICK) && !clear;

    // Synchronise the asynchronous pins and keep the previous pulse sample for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pulse_sync_q[i] <= '0;
            end
            gate_sync_q  <= '0;
            pulse_prev_q <= '0;
        end else begin
            pulse_sync_q[0] <= pulse_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pulse_sync_q[i] <= pulse_sync_q[i-1];
            end
            gate_sync_q  <= {gate_sync_q[SYNC_STAGES-2:0], gate};
            pulse_prev_q <= pulse_sync_q[SYNC_STAGES-1];
        end
    end

    // Accumulator values including this clock's event, and their next state after clear/snapshot.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            inc_p[k]    = limit_inc(acc_p_q[k]);
            inc_m[k]    = limit_inc(acc_m_q[k]);
            acc_p_ev[k] = acc_p_q[k];
            acc_m_ev[k] = acc_m_q[k];
            ovf_ev[k]   = ovf_live_q[k];
            if (count_en && evt[k]) begin
                if (gate_s) begin
                    acc_p_ev[k] = inc_p[k][WIDTH-1:0];
                    ovf_ev[k]   = ovf_live_q[k] | inc_p[k][WIDTH];
                end else begin
                    acc_m_ev[k] = inc_m[k][WIDTH-1:0];
                    ovf_ev[k]   = ovf_live_q[k] | inc_m[k][WIDTH];
                end
            end
            acc_p_d[k] = (clear || snap) ? {WIDTH{1'b0}} : acc_p_ev[k];
            acc_m_d[k] = (clear || snap) ? {WIDTH{1'b0}} : acc_m_ev[k];
        end
        ovf_live_d = (clear || snap) ? {NCH{1'b0}} : ovf_ev;
    end

    // Per-channel plus/minus accumulators and live overflow flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NCH; k++) begin
                acc_p_q[k] <= '0;
                acc_m_q[k] <= '0;
            end
            ovf_live_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                acc_p_q[k] <= acc_p_d[k];
                acc_m_q[k] <= acc_m_d[k];
            end
            ovf_live_q <= ovf_live_d;
        end
    end

    // Period FSM: timebase, snapshot latching, data_valid strobe and period count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            data_valid_q <= 1'b0;
            period_cnt_q <= '0;
            count_p_q    <= '0;
            count_m_q    <= '0;
            overflow_q   <= '0;
        end else begin
            data_valid_q <= 1'b0;
            if (clear) begin
                state_q    <= IDLE;
                tick_cnt_q <= '0;
            end else begin
                if (snap) begin
                    tick_cnt_q <= '0;
                end else if (en_tick) begin
                    tick_cnt_q <= tick_cnt_q + TW'(1);
                end
                case (state_q)
                    IDLE: begin
                        if (en_tick) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (snap) begin
                            state_q      <= SNAP;
                            data_valid_q <= 1'b1;
                            period_cnt_q <= period_cnt_q + 32'd1;
                            overflow_q   <= ovf_ev;
                            for (int k = 0; k < NCH; k++) begin
                                count_p_q[k*WIDTH +: WIDTH] <= acc_p_ev[k];
                                count_m_q[k*WIDTH +: WIDTH] <= acc_m_ev[k];
                            end
                        end
                    end
                    SNAP: begin
                        state_q <= RUN;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign count_p    = count_p_q;
    assign count_m    = count_m_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign period_cnt = period_cnt_q;

endmodule
